// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, addressing modes, instruction field
// positions and the instruction-fetch FSM state encoding.
package sisc_pkg;

  localparam logic [3:0] NOOP   = 4'h0;
  localparam logic [3:0] LOD    = 4'h1;
  localparam logic [3:0] STR    = 4'h2;
  localparam logic [3:0] SWP    = 4'h3;
  localparam logic [3:0] BRA    = 4'h4;
  localparam logic [3:0] BRR    = 4'h5;
  localparam logic [3:0] BNE    = 4'h6;
  localparam logic [3:0] BNR    = 4'h7;
  localparam logic [3:0] ALU_OP = 4'h8;
  localparam logic [3:0] HLT    = 4'hF;

  localparam logic [3:0] am_imm = 4'h8;

  // Field map of the 32-bit SISC instruction word.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int MM_MSB  = 27;
  localparam int MM_LSB  = 24;
  localparam int RD_MSB  = 23;
  localparam int RD_LSB  = 20;
  localparam int RS_MSB  = 19;
  localparam int RS_LSB  = 16;
  localparam int RT_MSB  = 15;
  localparam int RT_LSB  = 12;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } ifetch_state_e;

endpackage

// File: rtl/ifetch.sv
// SISC instruction fetch: PC and IR registers with a three-state fetch FSM
// that issues one memory read per fetch_start and tolerates wait states.
module ifetch
  import sisc_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               fetch_start,
  input  logic               pc_write,
  input  logic               br_rel,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [3:0]         rd,
  output logic [3:0]         rs,
  output logic [3:0]         rt,
  output logic [15:0]        imm,
  output logic               ir_valid,
  output logic               busy
);

  ifetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  br_target;

  // Relative branches sign-extend the immediate so 0xFFFE steps back by two.
  always_comb begin
    if (br_rel) begin
      br_target = pc_q + ADDR_W'($signed(ir_q[IMM_MSB:IMM_LSB]));
    end else begin
      br_target = ADDR_W'(ir_q[IMM_MSB:IMM_LSB]);
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      IDLE: begin
        if (pc_write) pc_d = br_target;
        if (fetch_start) state_d = REQ;
      end
      // PC is frozen here so the outstanding address cannot move.
      REQ: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = DONE;
        end
      end
      DONE: begin
        if (pc_write) pc_d = br_target;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req  = (state_q == REQ);
  assign busy      = (state_q == REQ);
  assign ir_valid  = (state_q == DONE);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;

  assign opcode = ir_q[OPC_MSB:OPC_LSB];
  assign mm     = ir_q[MM_MSB:MM_LSB];
  assign rd     = ir_q[RD_MSB:RD_LSB];
  assign rs     = ir_q[RS_MSB:RS_LSB];
  assign rt     = ir_q[RT_MSB:RT_LSB];
  assign imm    = ir_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: fetch latency, wait states, branches, wrap,
// ignored requests during a fetch and asynchronous reset abort.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        fetch_start;
  logic        pc_write;
  logic        br_rel;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [15:0] pc;
  logic [31:0] ir;
  logic [3:0]  opcode, mm, rd, rs, rt;
  logic [15:0] imm;
  logic        ir_valid;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  ifetch #(.ADDR_W(16), .INSTR_W(32)) dut (
    .clk         (clk),
    .rst_f       (rst_f),
    .fetch_start (fetch_start),
    .pc_write    (pc_write),
    .br_rel      (br_rel),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .ir          (ir),
    .opcode      (opcode),
    .mm          (mm),
    .rd          (rd),
    .rs          (rs),
    .rt          (rt),
    .imm         (imm),
    .ir_valid    (ir_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts a fetch from IDLE at a negedge and returns at a negedge back in IDLE.
  task automatic fetch(input logic [15:0] addr, input logic [31:0] data, input int waits);
    logic [15:0] nxt;
    nxt = addr + 16'd1;
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    for (int i = 0; i < waits; i++) begin
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", {16'd0, imem_addr}, {16'd0, addr});
      @(negedge clk);
    end
    chk("req", {31'd0, imem_req}, 32'd1);
    chk("addr", {16'd0, imem_addr}, {16'd0, addr});
    chk("busy", {31'd0, busy}, 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("ir_valid", {31'd0, ir_valid}, 32'd1);
    chk("ir_load", ir, data);
    chk("pc_inc", {16'd0, pc}, {16'd0, nxt});
    chk("req_done", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("ir_valid_drop", {31'd0, ir_valid}, 32'd0);
  endtask

  task automatic branch(input logic rel, input logic [15:0] exp);
    pc_write = 1'b1;
    br_rel   = rel;
    @(negedge clk);
    pc_write = 1'b0;
    br_rel   = 1'b0;
    chk(rel ? "branch_rel_pc" : "branch_abs_pc", {16'd0, pc}, {16'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_f       = 1'b0;
    fetch_start = 1'b0;
    pc_write    = 1'b0;
    br_rel      = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", {16'd0, pc}, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_f = 1'b1;
    @(negedge clk);

    // Zero-wait fetch from address 0 and field decode.
    fetch(16'h0000, 32'h81230004, 0);
    chk("opcode", {28'd0, opcode}, 32'd8);
    chk("mm", {28'd0, mm}, 32'd1);
    chk("rd", {28'd0, rd}, 32'd2);
    chk("rs", {28'd0, rs}, 32'd3);
    chk("rt", {28'd0, rt}, 32'd0);
    chk("imm", {16'd0, imm}, 32'h0004);

    // Reach pc=5, then a fetch with three wait states.
    fetch(16'h0001, 32'h00000005, 0);
    branch(1'b0, 16'h0005);
    fetch(16'h0005, 32'h10000020, 3);

    // Absolute branch to 0x20 and fetch there.
    branch(1'b0, 16'h0020);
    fetch(16'h0020, 32'h0000000F, 0);

    // Land on pc=0x10 with imm 0xFFFE, then relative branch back by two.
    branch(1'b0, 16'h000F);
    fetch(16'h000F, 32'h0000FFFE, 1);
    branch(1'b1, 16'h000E);

    // PC wrap from 0xFFFF.
    fetch(16'h000E, 32'h0000FFFF, 0);
    branch(1'b0, 16'hFFFF);
    fetch(16'hFFFF, 32'h00000007, 0);

    // pc_write and fetch_start during REQ are ignored.
    fetch_start = 1'b1;
    @(negedge clk);
    pc_write = 1'b1;
    br_rel   = 1'b1;
    chk("req039_addr0", {16'd0, imem_addr}, 32'd0);
    @(negedge clk);
    chk("req039_addr1", {16'd0, imem_addr}, 32'd0);
    chk("req039_req", {31'd0, imem_req}, 32'd1);
    chk("req039_pc", {16'd0, pc}, 32'd0);
    imem_ack    = 1'b1;
    imem_rdata  = 32'h30000002;
    pc_write    = 1'b0;
    br_rel      = 1'b0;
    fetch_start = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("req039_valid", {31'd0, ir_valid}, 32'd1);
    chk("req039_ir", ir, 32'h30000002);
    chk("req039_pcinc", {16'd0, pc}, 32'd1);
    @(negedge clk);
    chk("req039_valid_drop", {31'd0, ir_valid}, 32'd0);
    chk("req039_no_queue", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("req039_still_idle", {31'd0, imem_req}, 32'd0);

    // Branch and fetch_start together in IDLE: fetch uses new pc.
    fetch_start = 1'b1;
    pc_write    = 1'b1;
    br_rel      = 1'b0;
    @(negedge clk);
    fetch_start = 1'b0;
    pc_write    = 1'b0;
    chk("req027_req", {31'd0, imem_req}, 32'd1);
    chk("req027_addr", {16'd0, imem_addr}, 32'd2);
    imem_ack   = 1'b1;
    imem_rdata = 32'h40000009;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("req027_pc", {16'd0, pc}, 32'd3);
    chk("req027_valid", {31'd0, ir_valid}, 32'd1);
    @(negedge clk);

    // Stray ack in IDLE.
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    @(negedge clk);
    imem_ack = 1'b0;
    chk("stray_ack_ir", ir, 32'h40000009);
    chk("stray_ack_pc", {16'd0, pc}, 32'd3);
    chk("stray_ack_valid", {31'd0, ir_valid}, 32'd0);

    // Asynchronous reset mid-REQ, late ack after release.
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    chk("abort_req_pre", {31'd0, imem_req}, 32'd1);
    #2;
    rst_f = 1'b0;
    #1;
    chk("abort_req", {31'd0, imem_req}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_pc", {16'd0, pc}, 32'd0);
    chk("abort_ir", ir, 32'd0);
    chk("abort_valid", {31'd0, ir_valid}, 32'd0);
    @(negedge clk);
    rst_f      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h55555555;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late_ack_ir", ir, 32'd0);
    chk("late_ack_pc", {16'd0, pc}, 32'd0);
    chk("late_ack_valid", {31'd0, ir_valid}, 32'd0);
    chk("late_ack_req", {31'd0, imem_req}, 32'd0);

    // First fetch after reset reads address 0.
    fetch(16'h0000, 32'h12345678, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter ADDR_W, default 16, instruction-memory address width and PC width.
REQ-002 Parameter INSTR_W, default 32, instruction word width; fixed at 32 for the SISC field map.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst_f  input  1  reset, asynchronous, active-low.
REQ-005 fetch_start  input  1  one-cycle pulse from the control FSM in its fetch state; requests the next instruction.
REQ-006 pc_write  input  1  load a branch target into PC this cycle.
REQ-007 br_rel  input  1  branch mode: 0 = absolute (PC <= imm), 1 = relative (PC <= PC + imm).
REQ-008 imem_req  output  1  instruction-memory read request.
REQ-009 imem_addr  output  ADDR_W  read address, equal to PC while imem_req is high.
REQ-010 imem_ack  input  1  memory returns valid imem_rdata this cycle.
REQ-011 imem_rdata  input  32  instruction word from memory.
REQ-012 pc  output  ADDR_W  current program counter.
REQ-013 ir  output  32  instruction register.
REQ-014 opcode, mm, rd, rs, rt  output  4 each  ir[31:28], ir[27:24], ir[23:20], ir[19:16], ir[15:12].
REQ-015 imm  output  16  ir[15:0].
REQ-016 ir_valid  output  1  one-cycle pulse: ir was loaded on the previous edge.
REQ-017 busy  output  1  high while a fetch is outstanding (state REQ).

Function
REQ-018 FSM states IDLE, REQ, DONE; IDLE -> REQ on fetch_start; REQ -> DONE on imem_ack; DONE -> IDLE unconditionally.
REQ-019 imem_req SHALL be high exactly in REQ; imem_addr SHALL equal pc and stay stable for the whole REQ interval.
REQ-020 On imem_ack in REQ: ir <= imem_rdata and pc <= pc + 1 (mod 2^ADDR_W, 0xFFFF wraps to 0x0000) at the same edge.
REQ-021 Minimum latency: fetch_start at edge N, imem_req high in cycle N+1; with ack in that cycle, ir updated at edge N+2, ir_valid high in cycle N+2.
REQ-022 Memory wait states: REQ held any number of cycles until imem_ack; no timeout.
REQ-023 imem_ack outside REQ SHALL be ignored; ir and pc unchanged.
REQ-024 fetch_start while in REQ or DONE SHALL be ignored (no queuing).
REQ-025 pc_write in IDLE or DONE: pc <= imm[ADDR_W-1:0] (br_rel=0) or pc + imm mod 2^ADDR_W (br_rel=1); imm taken from current ir.
REQ-026 pc_write in REQ SHALL be ignored so the outstanding address never changes.
REQ-027 pc_write and fetch_start in the same IDLE cycle: branch applied at that edge; the following REQ uses the new pc.
REQ-028 Decoded fields (REQ-014, REQ-015) SHALL be continuous slices of ir, not extra registers.
REQ-029 ir holds its value between fetches; the control FSM reads opcode/mm from it through decode..writeback.

Reset
REQ-030 rst_f low SHALL immediately force state IDLE, pc = 0, ir = 0, imem_req = 0, ir_valid = 0, busy = 0, independent of clk.
REQ-031 Reset during REQ aborts the fetch; a late imem_ack after reset release SHALL be ignored (REQ-023).
REQ-032 First fetch after reset reads address 0.

Structure
REQ-033 Shared package sisc_pkg holds opcode constants (NOOP, LOD, STR, SWP, BRA, BRR, BNE, BNR, ALU_OP, HLT), addressing-mode constant am_imm, field bit positions and the ifetch state encoding.
REQ-034 No sub-module: field slicing is inline; one FSM plus pc and ir registers.

Verification
REQ-035 Reset, fetch_start, ack same cycle, rdata 0x81230004 -> imem_addr 0, opcode 8, mm 1, rd 2, rs 3, imm 0x0004, pc 1, ir_valid one cycle.
REQ-036 pc=5, fetch_start, ack after 3 wait cycles -> imem_req high 4 cycles, imem_addr 5 throughout, then pc 6.
REQ-037 ir imm 0x0020, pc_write br_rel=0 in IDLE -> pc 0x0020; next fetch addresses 0x0020.
REQ-038 pc=0x0010, imm 0xFFFE, pc_write br_rel=1 -> pc 0x000E; pc=0xFFFF fetch -> pc 0x0000.
REQ-039 pc_write and second fetch_start during REQ -> imem_addr unchanged, exactly one ir load.
REQ-040 rst_f low mid-REQ, ack after release -> imem_req drops without clk, pc 0, ir 0, no ir_valid.
